// File: rtl/abl_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module      : abl_multicycle_core
//  Description : Parametrised multi-cycle ABL processor with a 4-entry GPR file,
//                a synchronous instruction ROM interface, valid/ready I/O ports,
//                HALT support and a retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module abl_multicycle_core #(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 256,
  parameter int RETIRE_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  localparam int c_dmem_aw = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_ldi  = 4'h1;
  localparam logic [3:0] c_op_add  = 4'h2;
  localparam logic [3:0] c_op_sub  = 4'h3;
  localparam logic [3:0] c_op_and  = 4'h4;
  localparam logic [3:0] c_op_or   = 4'h5;
  localparam logic [3:0] c_op_ld   = 4'h6;
  localparam logic [3:0] c_op_st   = 4'h7;
  localparam logic [3:0] c_op_bz   = 4'h8;
  localparam logic [3:0] c_op_bn   = 4'h9;
  localparam logic [3:0] c_op_jmp  = 4'hA;
  localparam logic [3:0] c_op_in   = 4'hB;
  localparam logic [3:0] c_op_out  = 4'hC;
  localparam logic [3:0] c_op_halt = 4'hD;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_W-1:0]       r_pc;
  logic [PC_W-1:0]       w_pc_nxt;
  logic [PC_W-1:0]       w_pc_inc;
  logic [PC_W-1:0]       w_target;
  logic [15:0]           r_ir;
  logic [DATA_W-1:0]     r_gpr [4];
  logic                  r_zero;
  logic                  r_neg;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_valid;
  logic [RETIRE_W-1:0]   r_retired;
  logic [DATA_W-1:0]     r_dmem [DMEM_DEPTH];

  logic [3:0]            w_op;
  logic [1:0]            w_rd;
  logic [1:0]            w_rs;
  logic [7:0]            w_imm;
  logic [DATA_W-1:0]     w_rd_val;
  logic [DATA_W-1:0]     w_rs_val;
  logic [c_dmem_aw-1:0]  w_dmem_addr;
  logic [DATA_W-1:0]     w_alu_res;

  logic                  w_gpr_we;
  logic [DATA_W-1:0]     w_gpr_wdata;
  logic                  w_flags_we;
  logic                  w_dmem_we;
  logic                  w_retire;
  logic                  w_out_load;
  logic                  w_out_clear;

  assign w_op        = r_ir[15:12];
  assign w_rd        = r_ir[11:10];
  assign w_rs        = r_ir[9:8];
  assign w_imm       = r_ir[7:0];
  assign w_rd_val    = r_gpr[w_rd];
  assign w_rs_val    = r_gpr[w_rs];
  assign w_dmem_addr = r_ir[c_dmem_aw-1:0];
  assign w_target    = r_ir[PC_W-1:0];
  assign w_pc_inc    = r_pc + PC_W'(1);

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      c_op_add: w_alu_res = w_rd_val + w_rs_val;
      c_op_sub: w_alu_res = w_rd_val - w_rs_val;
      c_op_and: w_alu_res = w_rd_val & w_rs_val;
      c_op_or:  w_alu_res = w_rd_val | w_rs_val;
      default:  w_alu_res = '0;
    endcase
  end

  // Next-state and datapath control; PC only moves when an instruction completes.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_gpr_we    = 1'b0;
    w_gpr_wdata = '0;
    w_flags_we  = 1'b0;
    w_dmem_we   = 1'b0;
    w_retire    = 1'b0;
    w_out_load  = 1'b0;
    w_out_clear = 1'b0;

    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = w_pc_inc;
        w_retire    = 1'b1;
        case (w_op)
          c_op_ldi: begin
            w_gpr_we    = 1'b1;
            w_gpr_wdata = DATA_W'(w_imm);
          end
          c_op_add, c_op_sub, c_op_and, c_op_or: begin
            w_gpr_we    = 1'b1;
            w_gpr_wdata = w_alu_res;
            w_flags_we  = 1'b1;
          end
          c_op_ld: begin
            w_gpr_we    = 1'b1;
            w_gpr_wdata = r_dmem[w_dmem_addr];
          end
          c_op_st:  w_dmem_we = 1'b1;
          c_op_bz:  if (r_zero) w_pc_nxt = w_target;
          c_op_bn:  if (r_neg)  w_pc_nxt = w_target;
          c_op_jmp: w_pc_nxt = w_target;
          c_op_in: begin
            w_state_nxt = S_WAIT_IN;
            w_pc_nxt    = r_pc;
            w_retire    = 1'b0;
          end
          c_op_out: begin
            w_state_nxt = S_WAIT_OUT;
            w_pc_nxt    = r_pc;
            w_retire    = 1'b0;
            w_out_load  = 1'b1;
          end
          c_op_halt: begin
            // HALT retires but keeps its own PC on the fetch address.
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
          end
          default: ;
        endcase
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          w_gpr_we    = 1'b1;
          w_gpr_wdata = in_data;
          w_pc_nxt    = w_pc_inc;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        if (out_ready) begin
          w_out_clear = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_retired   <= '0;
      for (int i = 0; i < 4; i++) r_gpr[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == S_DECODE) r_ir <= imem_rdata;
      if (w_gpr_we) r_gpr[w_rd] <= w_gpr_wdata;
      if (w_flags_we) begin
        r_zero <= (w_alu_res == '0);
        r_neg  <= w_alu_res[DATA_W-1];
      end
      if (w_out_load) begin
        r_out_data  <= w_rd_val;
        r_out_valid <= 1'b1;
      end else if (w_out_clear) begin
        r_out_valid <= 1'b0;
      end
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  // Data memory has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (!rst && w_dmem_we) r_dmem[w_dmem_addr] <= w_rd_val;
  end

  assign imem_addr = r_pc;
  assign in_ready  = (r_state == S_WAIT_IN);
  assign halted    = (r_state == S_HALT);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_abl_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_abl_multicycle_core
//  Description : Directed self-checking bench for abl_multicycle_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_abl_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;
  logic [3:0]  retired;

  logic [15:0] rom [256];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  int          cnt;

  abl_multicycle_core #(
    .DATA_W(8), .PC_W(8), .DMEM_DEPTH(16), .RETIRE_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_begin();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic release_rst();
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, output int c);
    c = 0;
    while (!halted && c < maxc) begin
      step(1);
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Basic arithmetic program and reset state
    load_begin();
    rom[0] = 16'h1005; rom[1] = 16'h1403; rom[2] = 16'h2100; rom[3] = 16'hD000;
    release_rst();
    chk("rst_pc", imem_addr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    wait_halt(100, cyc);
    chk("p1_cycles", cyc, 12);
    chk("p1_halted", halted, 1);
    chk("p1_r0", dut.r_gpr[0], 8'h08);
    chk("p1_r1", dut.r_gpr[1], 8'h03);
    chk("p1_zero", dut.r_zero, 0);
    chk("p1_neg", dut.r_neg, 0);
    chk("p1_retired", retired, 4);
    step(5);
    chk("p1_halt_pc_hold", imem_addr, 8'h03);
    chk("p1_halt_stays", halted, 1);

    // Flags and branches
    load_begin();
    rom[8'h00] = 16'h107F; rom[8'h01] = 16'h1481; rom[8'h02] = 16'h2100;
    rom[8'h03] = 16'h8010;
    rom[8'h10] = 16'h3100; rom[8'h11] = 16'h9020;
    rom[8'h12] = 16'h4400; rom[8'h13] = 16'h18F0; rom[8'h14] = 16'h5900;
    rom[8'h15] = 16'h9030; rom[8'h16] = 16'hD000;
    rom[8'h20] = 16'hD000; rom[8'h30] = 16'hD000;
    release_rst();
    step(9);
    chk("p2_add_wrap", dut.r_gpr[0], 8'h00);
    chk("p2_add_zero", dut.r_zero, 1);
    chk("p2_add_neg", dut.r_neg, 0);
    step(3);
    chk("p2_bz_taken", imem_addr, 8'h10);
    step(6);
    chk("p2_sub", dut.r_gpr[0], 8'h7F);
    chk("p2_sub_zero", dut.r_zero, 0);
    chk("p2_sub_neg", dut.r_neg, 0);
    chk("p2_bn_not_taken", imem_addr, 8'h12);
    wait_halt(100, cyc);
    chk("p2_halted", halted, 1);
    chk("p2_and", dut.r_gpr[1], 8'h01);
    chk("p2_or", dut.r_gpr[2], 8'hF1);
    chk("p2_or_neg", dut.r_neg, 1);
    chk("p2_or_zero", dut.r_zero, 0);
    chk("p2_bn_taken", imem_addr, 8'h30);
    chk("p2_retired", retired, 11);

    // I/O handshakes and data memory
    load_begin();
    rom[0] = 16'hB800; rom[1] = 16'hC800; rom[2] = 16'h7840; rom[3] = 16'h6C40;
    rom[4] = 16'h103C; rom[5] = 16'h7041; rom[6] = 16'h6401; rom[7] = 16'hD000;
    release_rst();
    step(2);
    chk("p3_in_ready_exec", in_ready, 0);
    step(1);
    cnt = 0;
    while (in_ready && cnt < 20) begin
      cnt++;
      if (cnt == 6) begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
      end
      step(1);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("p3_in_ready_cycles", cnt, 6);
    chk("p3_in_r2", dut.r_gpr[2], 8'hA5);
    step(3);
    chk("p3_out_valid_rise", out_valid, 1);
    chk("p3_out_data", out_data, 8'hA5);
    step(1);
    chk("p3_out_hold_valid1", out_valid, 1);
    chk("p3_out_hold_data1", out_data, 8'hA5);
    step(1);
    chk("p3_out_hold_valid2", out_valid, 1);
    chk("p3_out_hold_data2", out_data, 8'hA5);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("p3_out_valid_drop", out_valid, 0);
    chk("p3_out_data_kept", out_data, 8'hA5);
    wait_halt(100, cyc);
    chk("p3_halted", halted, 1);
    chk("p3_ld_r3", dut.r_gpr[3], 8'hA5);
    chk("p3_alias_r1", dut.r_gpr[1], 8'h3C);
    chk("p3_retired", retired, 8);

    // PC and retired-counter wrap
    load_begin();
    rom[8'h00] = 16'hA0FF; rom[8'hFF] = 16'h0000;
    release_rst();
    step(3);
    chk("p4_jmp", imem_addr, 8'hFF);
    step(3);
    chk("p4_pc_wrap", imem_addr, 8'h00);
    chk("p4_retired2", retired, 2);
    step(39);
    chk("p4_retired15", retired, 15);
    step(3);
    chk("p4_retired_wrap", retired, 0);

    // Reset during output wait and while halted
    load_begin();
    rom[0] = 16'h105A; rom[1] = 16'hC000;
    release_rst();
    step(6);
    chk("p5_out_valid", out_valid, 1);
    chk("p5_out_data", out_data, 8'h5A);
    rst = 1'b1;
    step(1);
    chk("p5_rst_out_valid", out_valid, 0);
    chk("p5_rst_out_data", out_data, 0);
    chk("p5_rst_pc", imem_addr, 0);
    chk("p5_rst_r0", dut.r_gpr[0], 0);
    chk("p5_rst_retired", retired, 0);
    rom[0] = 16'hD000;
    rom[1] = 16'h0000;
    step(1);
    rst = 1'b0;
    step(3);
    chk("p5_halt", halted, 1);
    chk("p5_halt_retired", retired, 1);
    rst = 1'b1;
    step(1);
    chk("p5_rst_halted", halted, 0);
    chk("p5_rst_halt_retired", retired, 0);
    rst = 1'b0;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
